spi_xfer_arb: RTL
=================

# spi_xfer_arb

Two-port SPI transaction arbiter that shares a single `spi_mnrch` SPI monarch between two requesters, e.g. the inertial sensor interface and the A2D interface. It latches one 16-bit command per port and grants the SPI monarch round-robin. It launches each transaction with a one-clock `wrt` pulse, waits for `done`, and returns the read word to the requester with a one-clock acknowledge.

## Interface
- `TIMEOUT_CYCLES`, default 2048: clk cycles allowed in WAIT before abort. Used only with `SPI_XFER_ARB_TIMEOUT_EN`.
- `clk` in 1: system clock, rising-edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `req0` in 1: one-cycle request pulse, port 0.
- `cmd0` in 16: command word, sampled with `req0`.
- `busy0` out 1: port 0 request is pending or in flight.
- `ack0` out 1: one-cycle pulse when port 0 transaction completes.
- `req1`, `cmd1`, `busy1`, `ack1`: same as above, for port 1.
- `rdata` out 16: read word from the last completed transaction.
- `err` out 1: timeout flag, qualified by `ackN`.
- `spi_wrt` out 1: transaction start pulse to the SPI monarch.
- `spi_wt_data` out 16: command word to the SPI monarch.
- `spi_done` in 1: SPI monarch done. Level signal; goes low the cycle after `spi_wrt`.
- `spi_rd_data` in 16: SPI monarch read shift register.

## Operation
- Per-port `pendN` flag and `cmdN` holding register. Output `busyN = pendN`.
- `reqN` while `pendN=1` is dropped: no state change, no ack.
- `reqN` in the same cycle as `ackN`:
  - the new request is accepted;
  - `pendN` stays 1 and the new command is latched.
- Round-robin pointer `last` names the port served most recently. Reset value is 1, so port 0 wins the first tie.
  - Both ports pending in IDLE: grant `!last`.
  - One port pending: grant that port.
- FSM states: IDLE, LAUNCH, WAIT, ACK.
  - IDLE → LAUNCH when any `pendN` is set. Latch `gnt`, load `spi_wt_data` from the granted command, update `last`.
  - LAUNCH: `spi_wrt=1` for exactly this one cycle. → WAIT unconditionally.
  - WAIT → ACK when `spi_done=1`. Capture `rdata <= spi_rd_data`.
  - ACK: pulse `ack[gnt]`, clear `pend[gnt]` (unless the same-cycle `req` rule applies). → IDLE.
- `spi_wt_data` is held from LAUNCH until the next grant.
- `rdata` is held until the next capture.

## Timing
- Reset values:
  - outputs: `spi_wrt=0`, `spi_wt_data=0`, `rdata=0`, `ack0=ack1=0`, `busy0=busy1=0`, `err=0`;
  - internal: state IDLE, `last=1`.
- All outputs are registered.
- `reqN` pulse at cycle T gives `busyN=1` at T+1.
- Uncontended start: state leaves IDLE at T+1, `spi_wrt` is high during T+2.
- `ackN` is asserted in the cycle after the edge where `spi_done` is sampled high. `rdata` is valid in that same cycle.
- Back-to-back: the other pending port's `spi_wrt` follows 2 cycles after the ACK cycle (ACK → IDLE → LAUNCH).
- `spi_done` high in IDLE, LAUNCH or ACK is ignored. Only WAIT samples it.
- Reset mid-transaction:
  - all pending requests are discarded, with no ack;
  - the SPI monarch shares `rst_n` and resets with it.

## Configuration
- `SPI_XFER_ARB_TIMEOUT_EN` defined:
  - a 16-bit counter is cleared on entering WAIT and increments each WAIT cycle;
  - when it reaches `TIMEOUT_CYCLES-1` without `spi_done`, → ACK with `err=1` and `rdata` unchanged;
  - `err` is cleared on the next normal ACK.
- Not defined:
  - no counter exists;
  - `err` is tied 0;
  - WAIT exits only on `spi_done`.

## Test plan
- `req0` with `cmd0=16'hA5C3`; SPI model returns `16'h1234` → `spi_wt_data=A5C3` with one `spi_wrt` pulse, then one `ack0` with `rdata=1234`, and `busy0` falls the cycle after.
- `req0` and `req1` in the same cycle after reset → port 0 is served first, then port 1. Exactly 2 `spi_wrt` pulses and 2 acks in order 0, 1.
- Both ports re-request on every ack for 8 transactions → grants strictly alternate 0, 1, 0, 1, …
- `req1` with `cmd1=0x1111`, then a second `req1` (`0x2222`) while `busy1=1` → only `0x1111` is sent and one `ack1`.
- `req1` asserted in the same cycle as `ack1` → a second transaction with the new `cmd1` and a second `ack1`.
- With `SPI_XFER_ARB_TIMEOUT_EN` and `TIMEOUT_CYCLES=64`, `spi_done` held low → `ack0` with `err=1` 64 cycles after entering WAIT, then the arbiter returns to IDLE and serves the next request normally with `err=0`.

Source files
------------

// File: rtl/spi_xfer_arb.sv
// spi_xfer_arb: two-port round-robin arbiter sharing one spi_mnrch SPI monarch.
// Define SPI_XFER_ARB_TIMEOUT_EN to enable the WAIT-state timeout and err flag.
module spi_xfer_arb #(
  parameter int unsigned TIMEOUT_CYCLES = 2048
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0,
  input  logic [15:0] cmd0,
  output logic        busy0,
  output logic        ack0,
  input  logic        req1,
  input  logic [15:0] cmd1,
  output logic        busy1,
  output logic        ack1,
  output logic [15:0] rdata,
  output logic        err,
  output logic        spi_wrt,
  output logic [15:0] spi_wt_data,
  input  logic        spi_done,
  input  logic [15:0] spi_rd_data
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LAUNCH = 2'd1;
  localparam logic [1:0] S_WAIT   = 2'd2;
  localparam logic [1:0] S_ACK    = 2'd3;

  if (TIMEOUT_CYCLES == 0 || TIMEOUT_CYCLES > 65536) begin : g_bad_timeout
    $error("spi_xfer_arb: TIMEOUT_CYCLES must be in 1..65536");
  end

  logic [1:0]  r_state;
  logic        r_pend0;
  logic        r_pend1;
  logic [15:0] r_cmd0;
  logic [15:0] r_cmd1;
  logic        r_last;
  logic        r_gnt;
  logic        r_spi_wrt;
  logic [15:0] r_wt_data;
  logic [15:0] r_rdata;
  logic        r_ack0;
  logic        r_ack1;

  logic w_clr0;
  logic w_clr1;
  logic w_gnt_next;
  logic w_timeout;

  assign w_clr0     = (r_state == S_ACK) && !r_gnt;
  assign w_clr1     = (r_state == S_ACK) &&  r_gnt;
  // Tie goes to the port not served last; otherwise the only pending port.
  assign w_gnt_next = (r_pend0 && r_pend1) ? !r_last : r_pend1;

  // A request during its own ACK cycle re-arms the port instead of being dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend0 <= 1'b0;
      r_cmd0  <= '0;
    end else if (req0 && (!r_pend0 || w_clr0)) begin
      r_pend0 <= 1'b1;
      r_cmd0  <= cmd0;
    end else if (w_clr0) begin
      r_pend0 <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend1 <= 1'b0;
      r_cmd1  <= '0;
    end else if (req1 && (!r_pend1 || w_clr1)) begin
      r_pend1 <= 1'b1;
      r_cmd1  <= cmd1;
    end else if (w_clr1) begin
      r_pend1 <= 1'b0;
    end
  end

`ifdef SPI_XFER_ARB_TIMEOUT_EN
  localparam logic [15:0] LP_TO_LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] r_cnt;
  logic        r_err;

  assign w_timeout = (r_state == S_WAIT) && !spi_done && (r_cnt == LP_TO_LAST);
  assign err       = r_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (r_state == S_LAUNCH) begin
      r_cnt <= '0;
    end else if (r_state == S_WAIT) begin
      r_cnt <= r_cnt + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err <= 1'b0;
    end else if ((r_state == S_WAIT) && spi_done) begin
      r_err <= 1'b0;
    end else if (w_timeout) begin
      r_err <= 1'b1;
    end
  end
`else
  assign w_timeout = 1'b0;
  assign err       = 1'b0;
`endif

  // Output pulses are set on the transition edge so they coincide with LAUNCH/ACK.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_gnt     <= 1'b0;
      r_last    <= 1'b1;
      r_spi_wrt <= 1'b0;
      r_wt_data <= '0;
      r_rdata   <= '0;
      r_ack0    <= 1'b0;
      r_ack1    <= 1'b0;
    end else begin
      r_spi_wrt <= 1'b0;
      r_ack0    <= 1'b0;
      r_ack1    <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (r_pend0 || r_pend1) begin
            r_state   <= S_LAUNCH;
            r_gnt     <= w_gnt_next;
            r_last    <= w_gnt_next;
            r_spi_wrt <= 1'b1;
            r_wt_data <= w_gnt_next ? r_cmd1 : r_cmd0;
          end
        end
        S_LAUNCH: begin
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (spi_done || w_timeout) begin
            r_state <= S_ACK;
            r_ack0  <= !r_gnt;
            r_ack1  <= r_gnt;
            if (spi_done) begin
              r_rdata <= spi_rd_data;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy0       = r_pend0;
  assign busy1       = r_pend1;
  assign ack0        = r_ack0;
  assign ack1        = r_ack1;
  assign rdata       = r_rdata;
  assign spi_wrt     = r_spi_wrt;
  assign spi_wt_data = r_wt_data;

endmodule
